// File: rtl/maze_path_replayer.sv
// rtl/maze_path_replayer.sv - direction stack capture and absolute-cell path replay for the maze solver
// Stores pushed/popped 2-bit moves, then streams the cells reached from (0,0) with bounds trapping.
module maze_path_replayer #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dir_push,
    input  logic          dir_pop,
    input  logic [1:0]    dir_in,
    input  logic          start,
    input  logic          clear,
    input  logic          step_ready,
    output logic          step_valid,
    output logic [3:0]    step_x,
    output logic [3:0]    step_y,
    output logic [1:0]    step_dir,
    output logic          step_last,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          at_goal,
    output logic          bound_err,
    output logic          overflow_err
);
    typedef enum logic [1:0] {S_LOAD, S_REPLAY, S_DONE, S_ERROR} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [1:0]    mem_q [DEPTH];
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [3:0]    step_x_q, step_x_d, step_y_q, step_y_d;
    logic [1:0]    step_dir_q, step_dir_d;
    logic          step_valid_q, step_valid_d, step_last_q, step_last_d;
    logic          done_q, done_d, at_goal_q, at_goal_d;
    logic          bound_err_q, bound_err_d, overflow_err_q, overflow_err_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          xfer;
    logic [1:0]    cur_dir;
    logic [3:0]    src_x, src_y, nxt_x, nxt_y;
    logic          nxt_oob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_LOAD;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            pos_x_q        <= '0;
            pos_y_q        <= '0;
            step_x_q       <= '0;
            step_y_q       <= '0;
            step_dir_q     <= '0;
            step_valid_q   <= 1'b0;
            step_last_q    <= 1'b0;
            done_q         <= 1'b0;
            at_goal_q      <= 1'b0;
            bound_err_q    <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            step_x_q       <= step_x_d;
            step_y_q       <= step_y_d;
            step_dir_q     <= step_dir_d;
            step_valid_q   <= step_valid_d;
            step_last_q    <= step_last_d;
            done_q         <= done_d;
            at_goal_q      <= at_goal_d;
            bound_err_q    <= bound_err_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= dir_in;
        end
    end

    // rd_ptr always names the next entry to load; on a transfer the next step chains off the one leaving
    always_comb begin
        xfer    = step_valid_q && step_ready;
        src_x   = xfer ? step_x_q : pos_x_q;
        src_y   = xfer ? step_y_q : pos_y_q;
        cur_dir = mem_q[rd_ptr_q[AW-1:0]];
        nxt_x   = src_x;
        nxt_y   = src_y;
        nxt_oob = 1'b0;
        case (cur_dir)
            2'b00: begin nxt_oob = (src_x == 4'd0);  nxt_x = src_x - 4'd1; end
            2'b01: begin nxt_oob = (src_y == 4'd15); nxt_y = src_y + 4'd1; end
            2'b10: begin nxt_oob = (src_y == 4'd0);  nxt_y = src_y - 4'd1; end
            default: begin nxt_oob = (src_x == 4'd15); nxt_x = src_x + 4'd1; end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        step_x_d       = step_x_q;
        step_y_d       = step_y_q;
        step_dir_d     = step_dir_q;
        step_valid_d   = step_valid_q;
        step_last_d    = step_last_q;
        done_d         = done_q;
        at_goal_d      = at_goal_q;
        bound_err_d    = bound_err_q;
        overflow_err_d = overflow_err_q;
        mem_we         = 1'b0;
        mem_waddr      = count_q[AW-1:0];

        if (clear) begin
            state_d        = S_LOAD;
            count_d        = '0;
            step_valid_d   = 1'b0;
            step_last_d    = 1'b0;
            done_d         = 1'b0;
            at_goal_d      = 1'b0;
            bound_err_d    = 1'b0;
            overflow_err_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (start) begin
                        if (count_q == '0) begin
                            state_d   = S_DONE;
                            done_d    = 1'b1;
                            at_goal_d = 1'b0;
                        end else begin
                            state_d  = S_REPLAY;
                            pos_x_d  = '0;
                            pos_y_d  = '0;
                            rd_ptr_d = '0;
                        end
                    end else if (dir_push && dir_pop && count_q != '0) begin
                        mem_we    = 1'b1;
                        mem_waddr = count_q[AW-1:0] - AW'(1);
                    end else if (dir_push) begin
                        if (count_q == FULL) begin
                            overflow_err_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + ONE;
                        end
                    end else if (dir_pop && count_q != '0) begin
                        count_d = count_q - ONE;
                    end
                end
                S_REPLAY: begin
                    if (xfer) begin
                        pos_x_d = step_x_q;
                        pos_y_d = step_y_q;
                        if (step_last_q) begin
                            state_d      = S_DONE;
                            step_valid_d = 1'b0;
                            step_last_d  = 1'b0;
                            done_d       = 1'b1;
                            at_goal_d    = (step_x_q == 4'd15) && (step_y_q == 4'd15);
                        end
                    end
                    if (!step_valid_q || (xfer && !step_last_q)) begin
                        if (nxt_oob) begin
                            state_d      = S_ERROR;
                            bound_err_d  = 1'b1;
                            step_valid_d = 1'b0;
                            step_last_d  = 1'b0;
                        end else begin
                            step_x_d     = nxt_x;
                            step_y_d     = nxt_y;
                            step_dir_d   = cur_dir;
                            step_valid_d = 1'b1;
                            step_last_d  = (rd_ptr_q + ONE) == count_q;
                            rd_ptr_d     = rd_ptr_q + ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy         = (state_q == S_REPLAY);
        step_valid   = step_valid_q;
        step_x       = step_x_q;
        step_y       = step_y_q;
        step_dir     = step_dir_q;
        step_last    = step_last_q;
        count        = count_q;
        done         = done_q;
        at_goal      = at_goal_q;
        bound_err    = bound_err_q;
        overflow_err = overflow_err_q;
    end
endmodule

// File: doc/maze_path_replayer.md
# maze_path_replayer

Consumer end of the maze solver's direction stack. Captures the 2-bit move directions the solver pushes and pops while it searches. On command it replays the final path from the origin (0,0) as a stream of absolute cells over a valid/ready handshake, one cell per transfer. It flags out-of-maze moves and buffer overflow, and reports whether the replayed path ends at the goal cell (15,15).

## Interface
- DEPTH, 256, maximum number of stored directions
- AW, 8, pointer width (log2 DEPTH)
- clk  in  1  sole clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- dir_push  in  1  store dir_in as the new top entry (LOAD only)
- dir_pop  in  1  discard the top entry (LOAD only; solver backtrack)
- dir_in  in  2  direction: UP=00 (x-1), RIGHT=01 (y+1), LEFT=10 (y-1), DOWN=11 (x+1)
- start  in  1  pulse; begin replay (LOAD only)
- clear  in  1  pulse; empty buffer, clear flags, return to LOAD
- step_ready  in  1  downstream accepts current step
- step_valid  out  1  step_x/step_y/step_dir/step_last are valid
- step_x, step_y  out  4 each  cell reached after applying step_dir
- step_dir  out  2  direction of this step
- step_last  out  1  this step is the final stored entry
- count  out  AW+1  number of stored entries, 0..DEPTH
- busy  out  1  state is REPLAY
- done  out  1  replay finished cleanly (sticky until clear)
- at_goal  out  1  done and final cell is (15,15)
- bound_err  out  1  a step would leave 0..15 (sticky)
- overflow_err  out  1  a push was attempted at count==DEPTH (sticky)

## Operation
- States: LOAD, REPLAY, DONE, ERROR. Reset state is LOAD.
- LOAD:
  - push with count<DEPTH: mem[count]<=dir_in, count+1.
  - push with count==DEPTH: ignored, overflow_err<=1.
  - pop with count>0: count-1. Pop with count==0: ignored, no flag.
  - push and pop together with count>0: mem[count-1]<=dir_in, count unchanged. With count==0 they act as a plain push.
- start in LOAD:
  - count==0: go to DONE, done=1, at_goal=0.
  - otherwise: position<=(0,0), rd_ptr<=0, go to REPLAY.
  - start is ignored in every other state.
- REPLAY:
  - The step register is loaded with mem[rd_ptr] applied to the current position. Steps leave in FIFO order, rd_ptr 0..count-1.
  - Bounds are checked before a step is presented. UP at x==0, LEFT at y==0, RIGHT at y==15 or DOWN at x==15 goes to ERROR with bound_err=1. That step is never shown with valid high.
  - Transfer occurs when step_valid && step_ready. The position then becomes (step_x,step_y) and rd_ptr increments.
  - Transfer of the step_last step goes to DONE. done<=1 and at_goal<=(step_x==15 && step_y==15).
- DONE/ERROR: hold all flags. Only clear leaves these states (to LOAD).
- clear from any state: count=0, all flags 0, step_valid=0, go to LOAD. clear has priority over start, push and pop in the same cycle.
- push and pop are ignored outside LOAD. The buffer is not modified during replay.
- Position arithmetic is 4-bit. No wrap is ever produced because out-of-range steps trap to ERROR.

## Timing
- Reset values: step_valid, step_x, step_y, step_dir, step_last, busy, done, at_goal, bound_err, overflow_err all 0; count=0.
- Push/pop take effect on the next edge. count updates one cycle after the strobe.
- start at edge N:
  - N+1: busy=1; the first step is presented at N+2.
  - If the first step is out of bounds, bound_err=1 at N+2 and busy=0.
- Back-to-back: with step_ready held high, one transfer per cycle with no bubbles. step_valid stays high across steps.
- Backpressure: while step_valid && !step_ready, all step_* outputs hold stable.
- Last transfer at edge M: at M+1, step_valid=0, busy=0, done=1, and at_goal is valid.
- Async reset asserted mid-replay: all outputs go to reset values immediately. Buffer contents are don't-care; count=0.

## Test plan
- Push RIGHT,RIGHT,DOWN, start, ready=1 → steps (0,1),(0,2),(1,2) on consecutive cycles; step_last only on (1,2); next cycle done=1, at_goal=0.
- Push 15×DOWN then 15×RIGHT, start → 30 steps, final step (15,15) with step_last=1; done=1, at_goal=1.
- Push DOWN,RIGHT,RIGHT, pop, pop, push DOWN, plus one push+pop cycle writing RIGHT → count=2, replay (1,0),(1,1).
- Push UP, start → step_valid never rises, bound_err=1 at start+2, state ERROR; clear → all flags 0, count=0.
- 257 pushes → count=256, overflow_err=1; start with ready toggling 1,0,0,0,1 → outputs stable during the 3 low cycles; 256 transfers in total.
- Assert rst low during replay of a 10-step path → step_valid, busy and count go to 0 immediately; after release, start is accepted with count==0, giving done=1 on the next cycle.
